nn_reg_bank: RTL and testbench

Parametrised multi-entry register bank that generalises the single-word `ld` registers used across the neural-network datapath. It holds DEPTH words of DW bits each. Words enter in one of two ways: a whole vector at once (parallel load) or one word per cycle (serial shift, acting as a sliding window). It exposes the full vector, a random-access read port, an occupancy count and a one-cycle fill pulse. It sits between the input/weight streams and the neuron MAC arrays, replacing ad-hoc fixed-width registers such as the 8-bit and 21-bit ones.

---
 rtl/nn_reg_bank_if.sv | 27 ++
 rtl/nn_reg_bank.sv | 45 ++++
 tb/tb_nn_reg_bank.sv | 125 ++++++++++++
 3 files changed

// File: rtl/nn_reg_bank_if.sv
// nn_reg_bank_if: control, data and status bundle between a producer and the register bank
interface nn_reg_bank_if #(
  parameter int DW = 8,
  parameter int DEPTH = 21
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(DEPTH);
  logic clr;
  logic ld;
  logic sh;
  logic [DW-1:0] din;
  logic [DW*DEPTH-1:0] in_vec;
  logic [SW-1:0] sel;
  logic [DW*DEPTH-1:0] out_vec;
  logic [DW-1:0] dout;
  logic [CW-1:0] count;
  logic full;
  logic fill_pulse;
  modport master (
    output clr, ld, sh, din, in_vec, sel,
    input  out_vec, dout, count, full, fill_pulse
  );
  modport slave (
    input  clr, ld, sh, din, in_vec, sel,
    output out_vec, dout, count, full, fill_pulse
  );
endinterface

// File: rtl/nn_reg_bank.sv
// nn_reg_bank: DEPTH x DW register bank with parallel load, sliding-window shift, read port and fill pulse
module nn_reg_bank #(
  parameter int DW = 8,
  parameter int DEPTH = 21
) (
  input logic clk,
  input logic rst,
  nn_reg_bank_if.slave b
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  logic [DW-1:0] mem [DEPTH];
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic fp;
  logic wr;
  always_comb begin
    wr = b.ld || b.sh;
    cnt_nx = b.ld ? FULL_CNT : (cnt == FULL_CNT) ? cnt : cnt + CW'(1);
  end
  always_ff @(posedge clk) begin
    if (rst || b.clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      cnt <= '0;
      fp <= 1'b0;
    end else begin
      if (wr) cnt <= cnt_nx;
      fp <= wr && (cnt != FULL_CNT) && (cnt_nx == FULL_CNT);
      if (b.ld) begin
        for (int i = 0; i < DEPTH; i++) mem[i] <= b.in_vec[i*DW +: DW];
      end else if (b.sh) begin
        mem[0] <= b.din;
        for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
      end
    end
  end
  for (genvar g = 0; g < DEPTH; g++) begin : g_out
    assign b.out_vec[g*DW +: DW] = mem[g];
  end
  // Out-of-range selects read as zero rather than aliasing another entry
  assign b.dout = (int'(b.sel) < DEPTH) ? mem[b.sel] : '0;
  assign b.count = cnt;
  assign b.full = (cnt == FULL_CNT);
  assign b.fill_pulse = fp;
endmodule

// File: tb/tb_nn_reg_bank.sv
// tb_nn_reg_bank: directed checks of a DEPTH=4 bank and a DW=16/DEPTH=21 bank
module tb_nn_reg_bank;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_run = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  nn_reg_bank_if #(.DW(8), .DEPTH(4)) ia ();
  nn_reg_bank_if #(.DW(16), .DEPTH(21)) ib ();
  nn_reg_bank #(.DW(8), .DEPTH(4)) ua (.clk(clk), .rst(rst), .b(ia.slave));
  nn_reg_bank #(.DW(16), .DEPTH(21)) ub (.clk(clk), .rst(rst), .b(ib.slave));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_a();
    ia.clr = 0; ia.ld = 0; ia.sh = 0;
  endtask
  task automatic shift_a(input logic [7:0] d);
    idle_a();
    ia.sh = 1; ia.din = d;
    tick();
    ia.sh = 0;
  endtask
  initial begin
    idle_a();
    ia.din = 8'($urandom); ia.in_vec = $urandom; ia.sel = 0;
    ib.clr = 0; ib.ld = 0; ib.sh = 0; ib.din = 0; ib.in_vec = '0; ib.sel = 0;
    ia.ld = 1; ia.sh = 1; rst = 1;
    tick();
    rst = 0; idle_a();
    chk("rst out_vec", 64'(ia.out_vec), 0);
    chk("rst count", 64'(ia.count), 0);
    chk("rst full", 64'(ia.full), 0);
    chk("rst fill", 64'(ia.fill_pulse), 0);
    chk("rst big count", 64'(ib.count), 0);
    for (int s = 0; s < 4; s++) begin
      ia.sel = 2'(s); #1;
      chk($sformatf("rst dout%0d", s), 64'(ia.dout), 0);
    end
    // serial fill then sliding window
    shift_a(8'h11); chk("fill c1", 64'(ia.count), 1); chk("fill fp1", 64'(ia.fill_pulse), 0);
    shift_a(8'h22); chk("fill c2", 64'(ia.count), 2);
    shift_a(8'h33); chk("fill c3", 64'(ia.count), 3); chk("fill full3", 64'(ia.full), 0);
    shift_a(8'h44);
    chk("fill c4", 64'(ia.count), 4);
    chk("fill vec", 64'(ia.out_vec), 64'h11223344);
    chk("fill full", 64'(ia.full), 1);
    chk("fill fp", 64'(ia.fill_pulse), 1);
    shift_a(8'h55);
    chk("slide vec", 64'(ia.out_vec), 64'h22334455);
    chk("slide count", 64'(ia.count), 4);
    chk("slide fp", 64'(ia.fill_pulse), 0);
    tick();
    chk("hold vec", 64'(ia.out_vec), 64'h22334455);
    // parallel load wins over shift
    ia.clr = 1; tick(); idle_a();
    chk("clr count", 64'(ia.count), 0);
    ia.ld = 1; ia.sh = 1; ia.in_vec = 32'hA4A3A2A1; ia.din = 8'hFF;
    tick(); idle_a();
    chk("ld vec", 64'(ia.out_vec), 64'hA4A3A2A1);
    chk("ld count", 64'(ia.count), 4);
    chk("ld fp", 64'(ia.fill_pulse), 1);
    for (int s = 0; s < 4; s++) begin
      ia.sel = 2'(s); #1;
      chk($sformatf("rd dout%0d", s), 64'(ia.dout), 64'(8'hA1 + 8'(s)));
    end
    ia.ld = 1; ia.in_vec = 32'h01020304;
    tick(); idle_a();
    chk("reld vec", 64'(ia.out_vec), 64'h01020304);
    chk("reld count", 64'(ia.count), 4);
    chk("reld fp", 64'(ia.fill_pulse), 0);
    // clear beats load and shift
    ia.clr = 1; tick(); idle_a();
    shift_a(8'h01); shift_a(8'h02);
    chk("pre clr count", 64'(ia.count), 2);
    ia.clr = 1; ia.ld = 1; ia.sh = 1; ia.in_vec = 32'hDEADBEEF;
    tick(); idle_a();
    chk("clr vec", 64'(ia.out_vec), 0);
    chk("clr cnt", 64'(ia.count), 0);
    chk("clr fp", 64'(ia.fill_pulse), 0);
    // reset mid-fill restarts occupancy
    shift_a(8'h0A); shift_a(8'h0B); shift_a(8'h0C);
    rst = 1; tick(); rst = 0;
    chk("mid rst count", 64'(ia.count), 0);
    chk("mid rst vec", 64'(ia.out_vec), 0);
    shift_a(8'h1A); shift_a(8'h1B); shift_a(8'h1C);
    chk("refill full3", 64'(ia.full), 0);
    chk("refill fp3", 64'(ia.fill_pulse), 0);
    shift_a(8'h1D);
    chk("refill full4", 64'(ia.full), 1);
    chk("refill fp4", 64'(ia.fill_pulse), 1);
    chk("refill vec", 64'(ia.out_vec), 64'h1A1B1C1D);
    tick();
    chk("refill fp off", 64'(ia.fill_pulse), 0);
    // rst and clr together
    ia.clr = 1; rst = 1; tick(); rst = 0; idle_a();
    chk("rstclr count", 64'(ia.count), 0);
    chk("rstclr fp", 64'(ia.fill_pulse), 0);
    // wide/deep instance: saturation at 21, single pulse on 21st shift
    for (int i = 1; i <= 22; i++) begin
      ib.sh = 1; ib.din = 16'(i);
      tick();
      ib.sh = 0;
      chk($sformatf("big count%0d", i), 64'(ib.count), 64'((i > 21) ? 21 : i));
      chk($sformatf("big fp%0d", i), 64'(ib.fill_pulse), 64'(i == 21));
    end
    chk("big full", 64'(ib.full), 1);
    ib.sel = 0; #1;
    chk("big dout0", 64'(ib.dout), 22);
    ib.sel = 20; #1;
    chk("big dout20", 64'(ib.dout), 2);
    ib.sel = 25; #1;
    chk("big dout oob", 64'(ib.dout), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
